// File: rtl/mem_stage_unit_if.sv
// mem_stage_unit_if: data-memory req/ack handshake between the memory stage and data memory
interface mem_stage_unit_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory-stage access over req/ack, upstream stall, and MEM/WB result registers
module mem_stage_unit #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_regf_M,
  input  logic                wr_en_dmem_M,
  input  logic                rd_en_M,
  input  logic                out_port_sel_M,
  input  logic                is_ret_M,
  input  logic                mux_out_sel_M,
  input  logic [1:0]          mux_rdata_sel_M,
  input  logic [DW-1:0]       alu_out_M,
  input  logic [1:0]          rd_M,
  input  logic [DW-1:0]       IN_PORT_M,
  input  logic [AW-1:0]       mem_addr_M,
  input  logic [DW-1:0]       mem_wd_M,
  mem_stage_unit_if.master    dmem,
  output logic                stall_M,
  output logic                wr_en_regf_W,
  output logic [1:0]          rd_W,
  output logic [DW-1:0]       wb_data_W,
  output logic [DW-1:0]       ret_pc_W,
  output logic                ret_valid_W,
  output logic [DW-1:0]       out_port,
  output logic                mem_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          access, is_rd, complete, abort;
  logic [DW-1:0] rd_data, wb_sel;
  assign access   = rd_en_M | wr_en_dmem_M;
  assign is_rd    = rd_en_M & ~wr_en_dmem_M;
  assign complete = (state == IDLE) ? ~access : dmem.ack;
  assign abort    = (state == WAIT) & ~dmem.ack & (cnt == CW'(MAX_WAIT - 1));
  // stall is exactly "this instruction does not complete at the coming edge"
  assign stall_M  = reset & ~complete;
  assign rd_data  = is_rd ? dmem.rdata : '0;
  assign wb_sel   = mux_rdata_sel_M[1] ? (mux_rdata_sel_M[0] ? mem_wd_M : IN_PORT_M)
                                       : (mux_rdata_sel_M[0] ? rd_data : alu_out_M);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      dmem.req     <= 1'b0;
      dmem.we      <= 1'b0;
      dmem.addr    <= '0;
      dmem.wdata   <= '0;
      wr_en_regf_W <= 1'b0;
      rd_W         <= '0;
      wb_data_W    <= '0;
      ret_pc_W     <= '0;
      ret_valid_W  <= 1'b0;
      out_port     <= '0;
      mem_err      <= 1'b0;
    end else begin
      wr_en_regf_W <= complete & wr_en_regf_M;
      ret_valid_W  <= complete & is_ret_M & is_rd;
      mem_err      <= abort;
      if (complete) begin
        rd_W      <= rd_M;
        wb_data_W <= wb_sel;
        if (is_ret_M & is_rd) ret_pc_W <= dmem.rdata;
        if (out_port_sel_M) out_port <= mux_out_sel_M ? rd_data : alu_out_M;
      end
      if (state == IDLE) begin
        if (access) begin
          state      <= WAIT;
          cnt        <= '0;
          dmem.req   <= 1'b1;
          dmem.we    <= wr_en_dmem_M;
          dmem.addr  <= mem_addr_M;
          dmem.wdata <= mem_wd_M;
        end
      end else if (dmem.ack | abort) begin
        state    <= IDLE;
        dmem.req <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: directed steps with an expected-result queue checked on each completion
module tb_mem_stage_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en_regf_M, wr_en_dmem_M, rd_en_M, out_port_sel_M, is_ret_M, mux_out_sel_M;
  logic [1:0] mux_rdata_sel_M, rd_M;
  logic [7:0] alu_out_M, IN_PORT_M, mem_addr_M, mem_wd_M;
  logic       stall_M, wr_en_regf_W, ret_valid_W, mem_err;
  logic [1:0] rd_W;
  logic [7:0] wb_data_W, ret_pc_W, out_port;
  mem_stage_unit_if #(.DW(8), .AW(8)) dmem ();
  mem_stage_unit #(.DW(8), .AW(8), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .wr_en_regf_M(wr_en_regf_M), .wr_en_dmem_M(wr_en_dmem_M), .rd_en_M(rd_en_M),
    .out_port_sel_M(out_port_sel_M), .is_ret_M(is_ret_M), .mux_out_sel_M(mux_out_sel_M),
    .mux_rdata_sel_M(mux_rdata_sel_M), .alu_out_M(alu_out_M), .rd_M(rd_M),
    .IN_PORT_M(IN_PORT_M), .mem_addr_M(mem_addr_M), .mem_wd_M(mem_wd_M),
    .dmem(dmem), .stall_M(stall_M), .wr_en_regf_W(wr_en_regf_W), .rd_W(rd_W),
    .wb_data_W(wb_data_W), .ret_pc_W(ret_pc_W), .ret_valid_W(ret_valid_W),
    .out_port(out_port), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic we; logic [1:0] rd; logic [7:0] data;} exp_t;
  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  int   stall_cnt, req_cnt;
  logic err_seen, done, lat_we;
  logic [7:0] lat_addr, lat_wdata;
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    {wr_en_regf_M, wr_en_dmem_M, rd_en_M, out_port_sel_M, is_ret_M, mux_out_sel_M} = '0;
    mux_rdata_sel_M = 2'd0;
    rd_M = 2'd0;
    {alu_out_M, IN_PORT_M, mem_addr_M, mem_wd_M} = '0;
  endtask
  task automatic push(input logic we, input logic [1:0] rd, input logic [7:0] data);
    q.push_back('{we: we, rd: rd, data: data});
  endtask
  task automatic sb_check(input string tag);
    exp_t e;
    if (q.size() == 0) cmp({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = q.pop_front();
      cmp({tag, "_wen"}, wr_en_regf_W, e.we);
      cmp({tag, "_rd"}, rd_W, e.rd);
      cmp({tag, "_wb"}, wb_data_W, e.data);
    end
  endtask
  // memory model: ack on the ack_after-th cycle req is high (0 = never)
  task automatic run(input int ack_after, input logic [7:0] rdv);
    int seen = 0;
    stall_cnt = 0;
    req_cnt = 0;
    err_seen = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (dmem.req) begin
        seen++;
        lat_addr = dmem.addr;
        lat_we = dmem.we;
        lat_wdata = dmem.wdata;
      end
      dmem.ack = dmem.req && (seen == ack_after);
      dmem.rdata = dmem.ack ? rdv : 8'h00;
      #1;
      if (!stall_M) done = 1'b1;
      stall_cnt += int'(stall_M);
      req_cnt += int'(dmem.req);
      @(posedge clk);
      #1;
      dmem.ack = 1'b0;
      dmem.rdata = 8'h00;
      if (mem_err) begin
        err_seen = 1'b1;
        done = 1'b1;
      end
    end
    if (!done) cmp("run_bound", 32'd0, 32'd1);
  endtask
  initial begin
    reset = 1'b0;
    clr();
    dmem.ack = 1'b0;
    dmem.rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_req", dmem.req, 0);
    cmp("rst_stall", stall_M, 0);
    cmp("rst_wb", wb_data_W, 0);
    cmp("rst_out", out_port, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    alu_out_M = 8'h3C; rd_M = 2'd2; wr_en_regf_M = 1'b1;
    push(1'b1, 2'd2, 8'h3C);
    run(0, 8'h00);
    cmp("add_stall", stall_cnt, 0);
    sb_check("add");
    clr();
    run(0, 8'h00);
    cmp("add_single", wr_en_regf_W, 0);
    mem_addr_M = 8'h40; rd_en_M = 1'b1; mux_rdata_sel_M = 2'b01; rd_M = 2'd1; wr_en_regf_M = 1'b1;
    push(1'b1, 2'd1, 8'hA5);
    run(3, 8'hA5);
    cmp("ld_req_cycles", req_cnt, 3);
    cmp("ld_stall_cycles", stall_cnt, 3);
    cmp("ld_we", lat_we, 0);
    cmp("ld_addr", lat_addr, 8'h40);
    sb_check("ld");
    clr();
    run(0, 8'h00);
    cmp("ld_single", wr_en_regf_W, 0);
    cmp("ld_req_low", dmem.req, 0);
    mem_addr_M = 8'h10; mem_wd_M = 8'h77; wr_en_dmem_M = 1'b1; mux_rdata_sel_M = 2'b01; rd_M = 2'd3;
    push(1'b0, 2'd3, 8'h00);
    run(1, 8'hEE);
    cmp("st_we", lat_we, 1);
    cmp("st_wdata", lat_wdata, 8'h77);
    cmp("st_addr", lat_addr, 8'h10);
    cmp("st_stall_cycles", stall_cnt, 1);
    sb_check("st");
    clr();
    rd_en_M = 1'b1; is_ret_M = 1'b1; alu_out_M = 8'h11; mem_addr_M = 8'h80;
    out_port_sel_M = 1'b1; mux_out_sel_M = 1'b1;
    push(1'b0, 2'd0, 8'h11);
    run(2, 8'h5E);
    sb_check("ret");
    cmp("ret_pc", ret_pc_W, 8'h5E);
    cmp("ret_valid", ret_valid_W, 1);
    cmp("ret_out", out_port, 8'h5E);
    clr();
    run(0, 8'h00);
    cmp("ret_valid_pulse", ret_valid_W, 0);
    cmp("ret_pc_hold", ret_pc_W, 8'h5E);
    is_ret_M = 1'b1; alu_out_M = 8'h22;
    push(1'b0, 2'd0, 8'h22);
    run(0, 8'h00);
    cmp("ret_nord_valid", ret_valid_W, 0);
    sb_check("ret_nord");
    clr();
    out_port_sel_M = 1'b1; alu_out_M = 8'h81;
    push(1'b0, 2'd0, 8'h81);
    run(0, 8'h00);
    sb_check("out");
    cmp("out_port", out_port, 8'h81);
    clr();
    alu_out_M = 8'h12;
    push(1'b0, 2'd0, 8'h12);
    run(0, 8'h00);
    sb_check("out_next");
    cmp("out_hold", out_port, 8'h81);
    clr();
    IN_PORT_M = 8'hC3; mux_rdata_sel_M = 2'b10; rd_M = 2'd2; wr_en_regf_M = 1'b1; alu_out_M = 8'h01;
    push(1'b1, 2'd2, 8'hC3);
    run(0, 8'h00);
    sb_check("in");
    clr();
    rd_en_M = 1'b1; mem_addr_M = 8'h20; wr_en_regf_M = 1'b1; rd_M = 2'd3; alu_out_M = 8'h99;
    run(0, 8'h00);
    cmp("to_err", err_seen, 1);
    cmp("to_req_cycles", req_cnt, 4);
    cmp("to_stall_cycles", stall_cnt, 5);
    cmp("to_wen", wr_en_regf_W, 0);
    cmp("to_wb_hold", wb_data_W, 8'hC3);
    cmp("to_req_low", dmem.req, 0);
    clr();
    @(posedge clk);
    #1;
    cmp("to_err_pulse", mem_err, 0);
    dmem.ack = 1'b1;
    dmem.rdata = 8'hFF;
    #1;
    cmp("late_stall", stall_M, 0);
    @(posedge clk);
    #1;
    dmem.ack = 1'b0;
    dmem.rdata = 8'h00;
    cmp("late_req", dmem.req, 0);
    cmp("late_wen", wr_en_regf_W, 0);
    cmp("late_ret", ret_valid_W, 0);
    alu_out_M = 8'h44; rd_M = 2'd1; wr_en_regf_M = 1'b1;
    push(1'b1, 2'd1, 8'h44);
    run(0, 8'h00);
    cmp("late_add_stall", stall_cnt, 0);
    sb_check("late_add");
    clr();
    rd_en_M = 1'b1; mem_addr_M = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    cmp("mw_req_high", dmem.req, 1);
    reset = 1'b0;
    #1;
    cmp("mw_req", dmem.req, 0);
    cmp("mw_stall", stall_M, 0);
    cmp("mw_out", out_port, 0);
    cmp("mw_wb", wb_data_W, 0);
    cmp("mw_ret_pc", ret_pc_W, 0);
    cmp("mw_addr", dmem.addr, 0);
    clr();
    @(posedge clk);
    #1;
    reset = 1'b1;
    alu_out_M = 8'h3C; rd_M = 2'd2; wr_en_regf_M = 1'b1;
    push(1'b1, 2'd2, 8'h3C);
    run(0, 8'h00);
    cmp("mw_add_stall", stall_cnt, 0);
    sb_check("mw_add");
    clr();
    cmp("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
